// File: rtl/sobel_gradient_conv_pkg.sv
// Shared definitions for the streaming 3x3 Sobel gradient stage.
//   - Default widths for pixels, signed gradients and normalization divisors.
//   - Sobel kernel weights: the outer taps weigh 1 and the centre tap weighs 2.
//   - Row indices inside a packed column vector.
//   - Fill level at which the 3-column window is complete.
package sobel_gradient_conv_pkg;

  localparam int PIXEL_WIDTH   = 8;
  localparam int GRAD_WIDTH    = 12;
  localparam int DIVISOR_WIDTH = 6;

  localparam int W_OUTER  = 1;
  localparam int W_CENTER = 2;

  localparam int ROW_TOP = 0;
  localparam int ROW_MID = 1;
  localparam int ROW_BOT = 2;

  localparam logic [1:0] FILL_FULL = 2'd3;

endpackage

// File: rtl/sobel_gradient_conv_sum.sv
// Registered Sobel weighted sum a + 2b + c over three unsigned pixels.
// Ports:
//   clock  : rising-edge clock
//   a_i    : first outer tap (unsigned, pixel_width bits)
//   b_i    : centre tap (unsigned, pixel_width bits)
//   c_i    : second outer tap (unsigned, pixel_width bits)
//   sum_o  : registered sum (unsigned, pixel_width+2 bits)
// This block carries no valid logic; the parent tracks validity alongside it.
module sobel_weighted_sum
  import sobel_gradient_conv_pkg::*;
#(
  parameter int pixel_width = PIXEL_WIDTH
) (
  input  logic                   clock,
  input  logic [pixel_width-1:0] a_i,
  input  logic [pixel_width-1:0] b_i,
  input  logic [pixel_width-1:0] c_i,
  output logic [pixel_width+1:0] sum_o
);

  localparam int SW = pixel_width + 2;
  localparam logic [SW-1:0] K_OUTER  = SW'(W_OUTER);
  localparam logic [SW-1:0] K_CENTER = SW'(W_CENTER);

  logic [SW-1:0] sum_d;

  // Four times the maximum pixel value fits exactly in pixel_width+2 bits.
  always_comb begin
    sum_d = K_OUTER * {2'b00, a_i} + K_CENTER * {2'b00, b_i} + K_OUTER * {2'b00, c_i};
  end

  always_ff @(posedge clock) begin
    sum_o <= sum_d;
  end

endmodule

// File: rtl/sobel_gradient_conv.sv
// Streaming 3x3 Sobel convolution stage that feeds a pair of pipelined dividers.
// One pixel column (top/mid/bottom) arrives per valid cycle. Once three columns
// of the current line are in the window, the stage emits signed Gx/Gy dividends
// together with the divisor that arrived with the newest column.
// Latency is 2 cycles after the sampling edge. There is no backpressure.
// Ports:
//   clock         : rising-edge clock
//   reset         : synchronous, active-high
//   input_valid   : a column is present this cycle
//   line_start    : this column starts a new line (qualified by input_valid)
//   pix_top       : top-row pixel of the column
//   pix_mid       : middle-row pixel of the column
//   pix_bot       : bottom-row pixel of the column
//   norm_divisor  : normalization divisor sampled with the column
//   output_valid  : gx/gy/divisor valid this cycle
//   gx            : signed horizontal gradient
//   gy            : signed vertical gradient
//   divisor       : divisor aligned with gx/gy
module sobel_gradient_conv
  import sobel_gradient_conv_pkg::*;
#(
  parameter int pixel_width   = PIXEL_WIDTH,
  parameter int grad_width    = GRAD_WIDTH,
  parameter int divisor_width = DIVISOR_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           input_valid,
  input  logic                           line_start,
  input  logic        [pixel_width-1:0]  pix_top,
  input  logic        [pixel_width-1:0]  pix_mid,
  input  logic        [pixel_width-1:0]  pix_bot,
  input  logic        [divisor_width-1:0] norm_divisor,
  output logic                           output_valid,
  output logic signed [grad_width-1:0]   gx,
  output logic signed [grad_width-1:0]   gy,
  output logic        [divisor_width-1:0] divisor
);

  localparam int SW = pixel_width + 2;

  function automatic logic [1:0] fill_sat_inc(input logic [1:0] f);
    return (f == FILL_FULL) ? FILL_FULL : f + 2'd1;
  endfunction

  // Both sums are zero-extended before the subtraction, so the signed
  // difference cannot overflow as long as grad_width >= pixel_width+3.
  function automatic logic signed [grad_width-1:0] grad_diff(
    input logic [SW-1:0] pos,
    input logic [SW-1:0] neg
  );
    logic signed [grad_width-1:0] p;
    logic signed [grad_width-1:0] n;
    p = $signed(grad_width'(pos));
    n = $signed(grad_width'(neg));
    return p - n;
  endfunction

  // Window columns: c0 is the oldest, c2 the newest; element index = row.
  logic [2:0][pixel_width-1:0] c0_p0, c1_p0, c2_p0;
  logic [divisor_width-1:0]    div_p0, div_p1;
  logic                        vld_p0, vld_p1;
  logic [1:0]                  fill_q, fill_d;
  logic [SW-1:0]               gxp_p1, gxn_p1, gyp_p1, gyn_p1;

  // A line start restarts the count at 1. After reset the counter is 0, so
  // the first accepted column also lands at 1 and acts as a line start.
  always_comb begin
    fill_d = line_start ? 2'd1 : fill_sat_inc(fill_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fill_q       <= 2'd0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      output_valid <= 1'b0;
    end else begin
      if (input_valid) fill_q <= fill_d;
      vld_p0       <= input_valid && (fill_d == FILL_FULL);
      vld_p1       <= vld_p0;
      output_valid <= vld_p1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      c0_p0   <= '0;
      c1_p0   <= '0;
      c2_p0   <= '0;
      div_p0  <= '0;
      div_p1  <= '0;
      gx      <= '0;
      gy      <= '0;
      divisor <= '0;
    end else begin
      // Stage p0: shift the new column into the window.
      if (input_valid) begin
        c0_p0  <= c1_p0;
        c1_p0  <= c2_p0;
        c2_p0  <= {pix_bot, pix_mid, pix_top};
        div_p0 <= norm_divisor;
      end
      // Stage p1: partial sums are registered in the sub-modules.
      div_p1 <= div_p0;
      // Stage p2: final differences. The outputs hold when no result is present.
      if (vld_p1) begin
        gx      <= grad_diff(gxp_p1, gxn_p1);
        gy      <= grad_diff(gyp_p1, gyn_p1);
        divisor <= div_p1;
      end
    end
  end

  sobel_weighted_sum #(.pixel_width(pixel_width)) u_gx_pos (
    .clock (clock),
    .a_i   (c2_p0[ROW_TOP]),
    .b_i   (c2_p0[ROW_MID]),
    .c_i   (c2_p0[ROW_BOT]),
    .sum_o (gxp_p1)
  );

  sobel_weighted_sum #(.pixel_width(pixel_width)) u_gx_neg (
    .clock (clock),
    .a_i   (c0_p0[ROW_TOP]),
    .b_i   (c0_p0[ROW_MID]),
    .c_i   (c0_p0[ROW_BOT]),
    .sum_o (gxn_p1)
  );

  sobel_weighted_sum #(.pixel_width(pixel_width)) u_gy_pos (
    .clock (clock),
    .a_i   (c0_p0[ROW_BOT]),
    .b_i   (c1_p0[ROW_BOT]),
    .c_i   (c2_p0[ROW_BOT]),
    .sum_o (gyp_p1)
  );

  sobel_weighted_sum #(.pixel_width(pixel_width)) u_gy_neg (
    .clock (clock),
    .a_i   (c0_p0[ROW_TOP]),
    .b_i   (c1_p0[ROW_TOP]),
    .c_i   (c2_p0[ROW_TOP]),
    .sum_o (gyn_p1)
  );

endmodule

// File: tb/tb_sobel_gradient_conv.sv
// Scoreboard bench for sobel_gradient_conv. A reference model keeps the
// columns of the current line in queues and computes the Sobel gradients
// directly from the kernel formulas. A separate monitor compares every DUT
// output against the queued expectations, including the output cycle.
module tb_sobel_gradient_conv;

  localparam int PW = 8;
  localparam int GW = 12;
  localparam int DW = 6;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 input_valid = 1'b0;
  logic                 line_start = 1'b0;
  logic [PW-1:0]        pix_top = '0, pix_mid = '0, pix_bot = '0;
  logic [DW-1:0]        norm_divisor = '0;
  logic                 output_valid;
  logic signed [GW-1:0] gx, gy;
  logic [DW-1:0]        divisor;

  sobel_gradient_conv #(.pixel_width(PW), .grad_width(GW), .divisor_width(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .input_valid  (input_valid),
    .line_start   (line_start),
    .pix_top      (pix_top),
    .pix_mid      (pix_mid),
    .pix_bot      (pix_bot),
    .norm_divisor (norm_divisor),
    .output_valid (output_valid),
    .gx           (gx),
    .gy           (gy),
    .divisor      (divisor)
  );

  always #5 clock = ~clock;

  typedef struct {
    int gx;
    int gy;
    int dv;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   col_t[$], col_m[$], col_b[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_out = 0;

  // Reference model: observes the inputs at each rising edge.
  always @(posedge clock) begin
    exp_t e;
    cyc = cyc + 1;
    if (reset) begin
      sb.delete();
      col_t.delete();
      col_m.delete();
      col_b.delete();
    end else if (input_valid) begin
      if (line_start) begin
        col_t.delete();
        col_m.delete();
        col_b.delete();
      end
      col_t.push_back(int'(pix_top));
      col_m.push_back(int'(pix_mid));
      col_b.push_back(int'(pix_bot));
      if (col_t.size() > 3) begin
        void'(col_t.pop_front());
        void'(col_m.pop_front());
        void'(col_b.pop_front());
      end
      if (col_t.size() == 3) begin
        e.gx  = (col_t[2] + 2 * col_m[2] + col_b[2]) - (col_t[0] + 2 * col_m[0] + col_b[0]);
        e.gy  = (col_b[0] + 2 * col_b[1] + col_b[2]) - (col_t[0] + 2 * col_t[1] + col_t[2]);
        e.dv  = int'(norm_divisor);
        e.cyc = cyc + 2;
        sb.push_back(e);
      end
    end
  end

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    if (output_valid) begin
      n_out = n_out + 1;
      if (sb.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_output cycle=%0d gx=%0d gy=%0d", cyc, gx, gy);
      end else begin
        e = sb.pop_front();
        checks = checks + 4;
        if (int'(gx) != e.gx) begin
          errors = errors + 1;
          $display("FAIL gx cycle=%0d act=%0d exp=%0d", cyc, gx, e.gx);
        end
        if (int'(gy) != e.gy) begin
          errors = errors + 1;
          $display("FAIL gy cycle=%0d act=%0d exp=%0d", cyc, gy, e.gy);
        end
        if (int'(divisor) != e.dv) begin
          errors = errors + 1;
          $display("FAIL divisor cycle=%0d act=%0d exp=%0d", cyc, divisor, e.dv);
        end
        if (cyc != e.cyc) begin
          errors = errors + 1;
          $display("FAIL latency act_cycle=%0d exp_cycle=%0d", cyc, e.cyc);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL missing_output cycle=%0d exp_cycle=%0d exp_gx=%0d", cyc, e.cyc, e.gx);
    end
  end

  task automatic col(input bit ls, input int t, input int m, input int b, input int d);
    input_valid  = 1'b1;
    line_start   = ls;
    pix_top      = PW'(t);
    pix_mid      = PW'(m);
    pix_bot      = PW'(b);
    norm_divisor = DW'(d);
    @(posedge clock);
    #1;
    input_valid = 1'b0;
    line_start  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_count(input string name, input int base, input int expn);
    checks = checks + 1;
    if (n_out - base != expn) begin
      errors = errors + 1;
      $display("FAIL count_%s act=%0d exp=%0d", name, n_out - base, expn);
    end
  endtask

  task automatic check_reset_state(input string name);
    checks = checks + 1;
    if (output_valid !== 1'b0 || gx !== '0 || gy !== '0 || divisor !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_%s act=v%0b/%0d/%0d/%0d exp=v0/0/0/0", name, output_valid, gx, gy, divisor);
    end
  endtask

  initial begin
    int base;
    idle(3);
    reset = 1'b0;
    check_reset_state("initial");

    // Flat field: three zero-gradient outputs.
    base = n_out;
    col(1'b1, 100, 100, 100, 4);
    for (int i = 0; i < 4; i++) col(1'b0, 100, 100, 100, 4);
    idle(3);
    check_count("flat", base, 3);

    // Vertical edge: gx = +1020.
    base = n_out;
    col(1'b1, 0, 0, 0, 1);
    col(1'b0, 0, 0, 0, 1);
    col(1'b0, 255, 255, 255, 1);
    idle(3);
    check_count("vertical", base, 1);

    // Horizontal edge: gy = -1020.
    base = n_out;
    col(1'b1, 255, 128, 0, 3);
    col(1'b0, 255, 128, 0, 3);
    col(1'b0, 255, 128, 0, 3);
    idle(3);
    check_count("horizontal", base, 1);

    // Gaps between columns; the divisor of the third column is carried.
    base = n_out;
    col(1'b1, 0, 0, 0, 2);
    idle(1);
    col(1'b0, 0, 0, 0, 9);
    idle(2);
    col(1'b0, 255, 255, 255, 7);
    idle(3);
    check_count("gaps", base, 1);

    // Line restart on the sixth column.
    base = n_out;
    for (int i = 0; i < 8; i++) col(i == 0 || i == 5, i * 30, 200 - i * 20, i * 11, i + 1);
    idle(3);
    check_count("restart", base, 4);

    // Reset mid-stream while a third column is presented.
    base = n_out;
    col(1'b1, 10, 20, 30, 5);
    col(1'b0, 40, 50, 60, 6);
    reset = 1'b1;
    input_valid = 1'b1;
    pix_top = 8'd250;
    pix_mid = 8'd250;
    pix_bot = 8'd250;
    norm_divisor = 6'd11;
    @(posedge clock);
    #1;
    reset = 1'b0;
    input_valid = 1'b0;
    check_reset_state("midstream");
    col(1'b0, 200, 10, 0, 12);
    col(1'b0, 0, 90, 255, 13);
    col(1'b0, 17, 255, 3, 14);
    idle(3);
    check_count("reset", base, 1);

    // Randomized stream with gaps, restarts and occasional resets.
    for (int i = 0; i < 800; i++) begin
      reset        = ($urandom_range(0, 99) < 2);
      input_valid  = ($urandom_range(0, 99) < 70);
      line_start   = ($urandom_range(0, 99) < 8);
      pix_top      = PW'($urandom);
      pix_mid      = PW'($urandom);
      pix_bot      = PW'($urandom);
      norm_divisor = DW'($urandom);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    input_valid = 1'b0;
    line_start = 1'b0;
    idle(4);

    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
